// File: rtl/led_strip_pkg.sv
// Shared types and constants for the LED strip streamer: FSM states,
// default WS2812 timing at 50 MHz, and colour word layout.
package led_strip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    LATCH
  } state_e;

  localparam int unsigned T0H_CYC_DEF   = 20;
  localparam int unsigned T1H_CYC_DEF   = 40;
  localparam int unsigned BIT_CYC_DEF   = 63;
  localparam int unsigned LATCH_CYC_DEF = 4000;

  localparam int unsigned COLOUR_MSB    = 23;
  localparam int unsigned BITS_PER_LED  = 24;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/led_strip_streamer_if.sv
// Avalon-MM read-master bus between the streamer and the on-chip frame memory.
interface led_strip_streamer_if;
  logic [15:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable,
           mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable,
           mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/led_bit_encoder.sv
// NRZ bit-period generator: one load starts a BIT_CYC period whose high phase
// length depends on the bit value; bit_done flags the period's last cycle.
module led_bit_encoder
  import led_strip_pkg::*;
#(
  parameter int unsigned T0H_CYC = T0H_CYC_DEF,
  parameter int unsigned T1H_CYC = T1H_CYC_DEF,
  parameter int unsigned BIT_CYC = BIT_CYC_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic bit_val,
  output logic dout,
  output logic bit_done
);

  localparam int unsigned CW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] T0H  = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H  = CW'(T1H_CYC);

  logic [CW-1:0] cnt;
  logic [CW-1:0] high_len;
  logic          active;

  assign bit_done = active && (cnt == LAST);

  // A load on the last cycle of a period restarts cleanly, giving gapless bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      high_len <= '0;
      active   <= 1'b0;
      dout     <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      high_len <= bit_val ? T1H : T0H;
      active   <= 1'b1;
      dout     <= (bit_val ? T1H : T0H) != '0;
    end else if (bit_done) begin
      active   <= 1'b0;
      dout     <= 1'b0;
    end else if (active) begin
      cnt      <= cnt + 1'b1;
      dout     <= (cnt + 1'b1) < high_len;
    end
  end

endmodule

// File: rtl/led_strip_streamer.sv
// Reads one colour word per LED from on-chip memory and streams it MSB first
// as WS2812 NRZ bits, prefetching the next word during bit 23 of the current one.
module led_strip_streamer
  import led_strip_pkg::*;
#(
  parameter int unsigned T0H_CYC   = T0H_CYC_DEF,
  parameter int unsigned T1H_CYC   = T1H_CYC_DEF,
  parameter int unsigned BIT_CYC   = BIT_CYC_DEF,
  parameter int unsigned LATCH_CYC = LATCH_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [15:0]          base_addr,
  input  logic [15:0]          num_leds,
  output logic                 busy,
  output logic                 done,
  output logic                 led_dout,
  led_strip_streamer_if.master mem
);

  localparam int unsigned LW = cnt_width(BIT_CYC, LATCH_CYC);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYC - 2);

  state_e        state;
  logic [23:0]   sreg;
  logic [23:0]   pf;
  logic [4:0]    bit_idx;
  logic [15:0]   leds_left;
  logic [LW-1:0] lcnt;
  logic          rd_pending;
  logic [15:0]   addr;
  logic          cs;
  logic          enc_load;
  logic          enc_bit;
  logic          bit_done;
  logic          unused_msb;

  assign mem.mem_address    = addr;
  assign mem.mem_chipselect = cs;
  assign mem.mem_write      = 1'b0;
  assign mem.mem_byteenable = '1;
  assign mem.mem_writedata  = '0;
  assign mem.mem_clken      = 1'b1;
  assign unused_msb         = ^mem.mem_readdata[31:24];

  led_bit_encoder #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_enc (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (enc_load),
    .bit_val  (enc_bit),
    .dout     (led_dout),
    .bit_done (bit_done)
  );

  // Next bit is always sreg[22]: the current bit sits at [23] and shifts out.
  always_comb begin
    enc_load = 1'b0;
    enc_bit  = sreg[22];
    if (state == LOAD) begin
      enc_load = 1'b1;
      enc_bit  = mem.mem_readdata[COLOUR_MSB];
    end else if (state == SHIFT && bit_done) begin
      if (bit_idx != 5'd0) begin
        enc_load = 1'b1;
      end else if (leds_left != 16'd0) begin
        enc_load = 1'b1;
        enc_bit  = pf[COLOUR_MSB];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cs         <= 1'b0;
      addr       <= '0;
      sreg       <= '0;
      pf         <= '0;
      bit_idx    <= '0;
      leds_left  <= '0;
      lcnt       <= '0;
      rd_pending <= 1'b0;
    end else begin
      done       <= 1'b0;
      cs         <= 1'b0;
      rd_pending <= cs;
      if (rd_pending) pf <= mem.mem_readdata[23:0];
      case (state)
        IDLE: begin
          if (start) begin
            if (num_leds == 16'd0) begin
              done <= 1'b1;
            end else begin
              state     <= FETCH;
              busy      <= 1'b1;
              cs        <= 1'b1;
              addr      <= base_addr;
              leds_left <= num_leds - 16'd1;
            end
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          sreg    <= mem.mem_readdata[23:0];
          bit_idx <= 5'(COLOUR_MSB);
          state   <= SHIFT;
          if (leds_left != 16'd0) begin
            cs   <= 1'b1;
            addr <= addr + 16'd1;
          end
        end
        SHIFT: begin
          if (bit_done) begin
            if (bit_idx != 5'd0) begin
              sreg    <= sreg << 1;
              bit_idx <= bit_idx - 5'd1;
            end else if (leds_left != 16'd0) begin
              sreg      <= pf;
              bit_idx   <= 5'(COLOUR_MSB);
              leds_left <= leds_left - 16'd1;
              if (leds_left != 16'd1) begin
                cs   <= 1'b1;
                addr <= addr + 16'd1;
              end
            end else begin
              state <= LATCH;
              lcnt  <= '0;
            end
          end
        end
        // The done cycle itself is the final low cycle of the latch period.
        LATCH: begin
          if (lcnt == LATCH_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
